// File: rtl/spi_master_byte_if.sv
// Host-side handshake plus SPI pins of the byte-wide SPI master.
//   master modport : view of the SPI master itself (drives SCK/MOSI/SSEL, DONE/BUSY/DATA_IN)
//   slave modport  : view of whatever sits opposite (host stimulus and SPI slave)
// Signals:
//   START, LAST, DATA_OUT : host request, last-byte flag, byte to send
//   DATA_IN, BUSY, DONE   : received byte, transfer active, byte-complete pulse
//   SCK, MOSI, SSEL, MISO : SPI mode-0 pins (SSEL active low)
interface spi_master_byte_if;
  logic       START;
  logic       LAST;
  logic [7:0] DATA_OUT;
  logic [7:0] DATA_IN;
  logic       BUSY;
  logic       DONE;
  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       SSEL;

  modport master (
    input  START, LAST, DATA_OUT, MISO,
    output DATA_IN, BUSY, DONE, SCK, MOSI, SSEL
  );

  modport slave (
    output START, LAST, DATA_OUT, MISO,
    input  DATA_IN, BUSY, DONE, SCK, MOSI, SSEL
  );
endinterface

// File: rtl/spi_master_byte.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master, MSB first, one byte per host request.
// SSEL is held low across consecutive bytes until a byte flagged LAST completes.
// Ports:
//   clk  : system clock, all logic on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_byte_if.master (host handshake + SPI pins), all outputs registered
module spi_master_byte #(
  parameter int unsigned CLK_DIV    = 4,  // clk cycles per SCK half-period
  parameter int unsigned SSEL_SETUP = 4,  // SSEL low before first SCK half-period
  parameter int unsigned SSEL_HOLD  = 4   // SSEL low after last fall, then high before IDLE
) (
  input logic              clk,
  input logic              rst,
  spi_master_byte_if.master bus
);

  localparam int unsigned MAX_A   = (CLK_DIV > SSEL_SETUP) ? CLK_DIV : SSEL_SETUP;
  localparam int unsigned MAX_CNT = (MAX_A > SSEL_HOLD) ? MAX_A : SSEL_HOLD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SSEL_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(SSEL_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, WAIT, HOLD, DESEL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitcnt;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic             last_q;
  logic             sck_q;
  logic             mosi_q;
  logic             ssel_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       data_in_q;

  assign bus.SCK     = sck_q;
  assign bus.MOSI    = mosi_q;
  assign bus.SSEL    = ssel_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.DATA_IN = data_in_q;

  // Transfer sequencer; MOSI is updated alongside tx_shift so it only moves on load or SCK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      last_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ssel_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_in_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            tx_shift <= bus.DATA_OUT;
            mosi_q   <= bus.DATA_OUT[7];
            last_q   <= bus.LAST;
            bitcnt   <= '0;
            cnt      <= '0;
            ssel_q   <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == SETUP_END) begin
            cnt   <= '0;
            state <= LOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LOW: begin
          if (cnt == DIV_END) begin
            cnt      <= '0;
            sck_q    <= 1'b1;
            rx_shift <= {rx_shift[6:0], bus.MISO};
            state    <= HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HIGH: begin
          if (cnt == DIV_END) begin
            cnt   <= '0;
            sck_q <= 1'b0;
            if (bitcnt != 3'd7) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              mosi_q   <= tx_shift[6];
              bitcnt   <= bitcnt + 3'd1;
              state    <= LOW;
            end else begin
              data_in_q <= rx_shift;
              done_q    <= 1'b1;
              state     <= last_q ? HOLD : WAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // BUSY drops one cycle after DONE, so a START coincident with DONE is ignored.
        WAIT: begin
          if (bus.START && !done_q) begin
            tx_shift <= bus.DATA_OUT;
            mosi_q   <= bus.DATA_OUT[7];
            last_q   <= bus.LAST;
            bitcnt   <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= LOW;
          end else begin
            busy_q <= 1'b0;
          end
        end

        HOLD: begin
          if (cnt == HOLD_END) begin
            cnt    <= '0;
            ssel_q <= 1'b1;
            mosi_q <= 1'b0;
            state  <= DESEL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DESEL: begin
          if (cnt == HOLD_END) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: default-parameter instance plus a CLK_DIV=7,
// SSEL_SETUP=5, SSEL_HOLD=9 instance. Cycle c=1 is the cycle right after the accepting edge.
module tb_spi_master_byte;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_byte_if bus ();
  spi_master_byte_if bus6 ();

  spi_master_byte u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_master_byte #(
    .CLK_DIV    (7),
    .SSEL_SETUP (5),
    .SSEL_HOLD  (9)
  ) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  // Mode-0 slave model: presents bit 7 first, advances on SCK fall, samples MOSI on rise.
  logic       loop_en;
  logic [7:0] slave_word;
  logic [7:0] slave_rx = 8'h00;
  int         slave_falls = 0;
  int         slave_base;
  int         slave_idx;
  logic       slave_bit;

  assign slave_idx = slave_falls - slave_base;
  assign slave_bit = (slave_idx >= 0 && slave_idx < 8) ? slave_word[3'(7 - slave_idx)] : 1'b0;
  assign bus.MISO  = loop_en ? bus.MOSI : slave_bit;
  assign bus6.MISO = bus6.MOSI;

  always @(posedge bus.SCK) slave_rx <= {slave_rx[6:0], bus.MOSI};
  always @(negedge bus.SCK) slave_falls <= slave_falls + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-transfer observations
  int         rises, dones, done_c, ssel_c, busy_c;
  logic [7:0] data_seen;
  logic       prev_sck;
  int         run, hi_min, hi_max, lo_min, lo_max, falls6;
  logic       ok;

  // Observe default instance for ncyc cycles starting at c=1.
  task automatic measure(input int ncyc, input int start_off_c);
    rises = 0; dones = 0; done_c = 0; ssel_c = 0; busy_c = 0; data_seen = 8'h00;
    prev_sck = bus.SCK;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.SCK && !prev_sck) rises++;
      prev_sck = bus.SCK;
      if (bus.DONE) begin
        dones++;
        if (done_c == 0) done_c = c;
        data_seen = bus.DATA_IN;
      end
      if (bus.SSEL && ssel_c == 0) ssel_c = c;
      if (!bus.BUSY && busy_c == 0) busy_c = c;
      if (c == 10) bus.DATA_OUT = 8'hC5;
      if (c == start_off_c) bus.START = 1'b0;
      tick();
    end
  endtask

  task automatic wait_done(input int limit, output logic seen, output logic ssel_hi);
    seen = 1'b0;
    ssel_hi = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (bus.DONE) begin
        seen = 1'b1;
        break;
      end
      if (bus.SSEL) ssel_hi = 1'b1;
      tick();
    end
  endtask

  logic seen, ssel_hi;

  initial begin
    rst = 1'b1;
    loop_en = 1'b1;
    slave_word = 8'h00;
    slave_base = 0;
    bus.START = 1'b0; bus.LAST = 1'b0; bus.DATA_OUT = 8'h00;
    bus6.START = 1'b0; bus6.LAST = 1'b0; bus6.DATA_OUT = 8'h00;
    repeat (3) tick();

    check("rst_ssel", 32'(bus.SSEL), 32'(1));
    check("rst_sck", 32'(bus.SCK), 32'(0));
    check("rst_mosi", 32'(bus.MOSI), 32'(0));
    check("rst_busy", 32'(bus.BUSY), 32'(0));
    check("rst_done", 32'(bus.DONE), 32'(0));
    check("rst_data_in", 32'(bus.DATA_IN), 32'(0));
    rst = 1'b0;
    repeat (2) tick();

    // 1: loopback 0xA5, LAST=1
    bus.DATA_OUT = 8'hA5; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("t1_ssel_low_c1", 32'(bus.SSEL), 32'(0));
    check("t1_busy_c1", 32'(bus.BUSY), 32'(1));
    bus.DATA_OUT = 8'hA5;
    measure(90, 1);
    check("t1_rises", 32'(rises), 32'(8));
    check("t1_dones", 32'(dones), 32'(1));
    check("t1_done_c", 32'(done_c), 32'(69));
    check("t1_data_in", 32'(data_seen), 32'(8'hA5));
    check("t1_ssel_hi_c", 32'(ssel_c), 32'(73));
    check("t1_busy_lo_c", 32'(busy_c), 32'(77));

    // 2: slave replies 0x3C,0x81 to 0xC3 (LAST=0), 0x01 (LAST=1)
    loop_en = 1'b0;
    slave_word = 8'h3C; slave_base = slave_falls;
    bus.DATA_OUT = 8'hC3; bus.LAST = 1'b0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    wait_done(200, seen, ssel_hi);
    check("t2_done1_seen", 32'(seen), 32'(1));
    check("t2_data_in1", 32'(bus.DATA_IN), 32'(8'h3C));
    check("t2_slave_rx1", 32'(slave_rx), 32'(8'hC3));
    slave_word = 8'h81; slave_base = slave_falls;
    tick();
    check("t2_busy_after_done", 32'(bus.BUSY), 32'(0));
    check("t2_ssel_in_wait", 32'(bus.SSEL), 32'(0));
    bus.DATA_OUT = 8'h01; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    wait_done(200, seen, ssel_hi);
    check("t2_done2_seen", 32'(seen), 32'(1));
    check("t2_data_in2", 32'(bus.DATA_IN), 32'(8'h81));
    check("t2_slave_rx2", 32'(slave_rx), 32'(8'h01));
    check("t2_ssel_stayed_low", 32'(ssel_hi), 32'(0));
    repeat (12) tick();
    check("t2_idle_busy", 32'(bus.BUSY), 32'(0));
    check("t2_idle_ssel", 32'(bus.SSEL), 32'(1));

    // 3: START in DONE cycle ignored, 100-cycle WAIT, then DONE 64 edges after START
    loop_en = 1'b1;
    bus.DATA_OUT = 8'h66; bus.LAST = 1'b0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    wait_done(200, seen, ssel_hi);
    check("t3_done1_seen", 32'(seen), 32'(1));
    check("t3_busy_in_done_cycle", 32'(bus.BUSY), 32'(1));
    bus.DATA_OUT = 8'h11; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    ok = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (bus.SSEL || bus.SCK || bus.BUSY || bus.DONE) ok = 1'b0;
      tick();
    end
    check("t3_wait_quiet", 32'(ok), 32'(1));
    check("t3_data_in1", 32'(bus.DATA_IN), 32'(8'h66));
    bus.DATA_OUT = 8'h99; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.DATA_OUT = 8'h99;
    measure(100, 1);
    check("t3_done_c", 32'(done_c), 32'(65));
    check("t3_data_in2", 32'(data_seen), 32'(8'h99));
    check("t3_rises", 32'(rises), 32'(8));

    // 4: START held every cycle during a byte; DATA_OUT changes at c=10
    bus.DATA_OUT = 8'h3A; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    measure(90, 74);
    check("t4_rises", 32'(rises), 32'(8));
    check("t4_dones", 32'(dones), 32'(1));
    check("t4_data_in", 32'(data_seen), 32'(8'h3A));
    check("t4_busy_lo_c", 32'(busy_c), 32'(77));

    // 5: reset between 3rd and 4th SCK rise
    bus.DATA_OUT = 8'hE7; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    rises = 0;
    prev_sck = bus.SCK;
    for (int n = 0; n < 60 && rises < 3; n++) begin
      tick();
      if (bus.SCK && !prev_sck) rises++;
      prev_sck = bus.SCK;
    end
    check("t5_third_rise", 32'(rises), 32'(3));
    tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ssel", 32'(bus.SSEL), 32'(1));
    check("t5_rst_sck", 32'(bus.SCK), 32'(0));
    check("t5_rst_busy", 32'(bus.BUSY), 32'(0));
    check("t5_rst_data_in", 32'(bus.DATA_IN), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    measure(80, 0);
    check("t5_no_done", 32'(dones), 32'(0));
    bus.DATA_OUT = 8'h5A; bus.LAST = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.DATA_OUT = 8'h5A;
    measure(90, 1);
    check("t5_after_done_c", 32'(done_c), 32'(69));
    check("t5_after_data_in", 32'(data_seen), 32'(8'h5A));

    // 6: CLK_DIV=7, SSEL_SETUP=5, SSEL_HOLD=9, loopback 0xFF
    bus6.DATA_OUT = 8'hFF; bus6.LAST = 1'b1; bus6.START = 1'b1;
    tick();
    bus6.START = 1'b0;
    rises = 0; dones = 0; done_c = 0; ssel_c = 0; busy_c = 0; data_seen = 8'h00;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0; falls6 = 0; run = 0;
    prev_sck = bus6.SCK;
    for (int c = 1; c <= 160; c++) begin
      if (bus6.SCK == prev_sck) begin
        run++;
      end else begin
        if (!bus6.SCK) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
          falls6++;
        end else begin
          rises++;
          if (falls6 > 0) begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
        end
        run = 1;
      end
      prev_sck = bus6.SCK;
      if (bus6.DONE) begin
        dones++;
        if (done_c == 0) done_c = c;
        data_seen = bus6.DATA_IN;
      end
      if (bus6.SSEL && ssel_c == 0) ssel_c = c;
      if (!bus6.BUSY && busy_c == 0) busy_c = c;
      tick();
    end
    check("t6_rises", 32'(rises), 32'(8));
    check("t6_dones", 32'(dones), 32'(1));
    check("t6_done_c", 32'(done_c), 32'(118));
    check("t6_data_in", 32'(data_seen), 32'(8'hFF));
    check("t6_hi_min", 32'(hi_min), 32'(7));
    check("t6_hi_max", 32'(hi_max), 32'(7));
    check("t6_lo_min", 32'(lo_min), 32'(7));
    check("t6_lo_max", 32'(lo_max), 32'(7));
    check("t6_ssel_hold", 32'(ssel_c - done_c), 32'(9));
    check("t6_busy_lo_c", 32'(busy_c), 32'(136));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
